// File: rtl/ring_osc_freq_meter.sv
// Ring oscillator frequency meter.
// Enables the ring, lets it settle, then counts synchronized ring rising edges
// over a gate window of gate_len clk cycles. The count is reported with a
// one-cycle done pulse. Frequency = result / gate_len * f_clk.
//
// Control handshake: start is a level sampled only in IDLE. A start is
// accepted when state is IDLE, start=1 and abort=0. busy stays high from the
// cycle after acceptance through the done cycle. result/ovf are valid while
// done is high and hold until the next completed measurement.
module ring_osc_freq_meter #(
   parameter int CNT_W         = 24,
   parameter int GATE_W        = 20,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              ring_in,
   output logic              ring_en,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  result,
   output logic              ovf
);

   typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state_q;
   state_t              state_d;
   logic                s1, s2, s3;
   logic                rise;
   logic [SET_W-1:0]    settle_cnt;
   logic [GATE_W-1:0]   gate_q;
   logic [GATE_W-1:0]   gate_cnt;
   logic [CNT_W-1:0]    edge_cnt;
   logic [CNT_W-1:0]    edge_next;
   logic                sat;
   logic                sat_next;
   logic                accept;
   logic                edge_inc;
   logic                at_max;

   // Two-flop synchronizer plus history flop for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= ring_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   // Start acceptance and saturating next edge count.
   always_comb begin
      accept    = (state_q == IDLE) && start && !abort;
      edge_inc  = (state_q == COUNT) && rise;
      at_max    = (edge_cnt == CNT_MAX);
      edge_next = edge_cnt;
      sat_next  = sat;
      if (edge_inc) begin
         if (at_max) sat_next = 1'b1;
         else        edge_next = edge_cnt + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; abort only matters while the ring is enabled.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = (gate_len == '0) ? DONE : SETTLE;
         end
         SETTLE: begin
            if (abort)                  state_d = IDLE;
            else if (settle_cnt == '0)  state_d = COUNT;
         end
         COUNT: begin
            if (abort)                  state_d = IDLE;
            else if (gate_cnt == '0)    state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: counters, latched gate length, and result capture on DONE entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         gate_q     <= '0;
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         sat        <= 1'b0;
         result     <= '0;
         ovf        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  gate_q     <= gate_len;
                  settle_cnt <= SETTLE_LOAD;
                  edge_cnt   <= '0;
                  sat        <= 1'b0;
                  if (gate_len == '0) begin
                     result <= '0;
                     ovf    <= 1'b0;
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  edge_cnt <= '0;
                  sat      <= 1'b0;
                  gate_cnt <= gate_q - 1'b1;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            COUNT: begin
               edge_cnt <= edge_next;
               sat      <= sat_next;
               gate_cnt <= gate_cnt - 1'b1;
               if (gate_cnt == '0 && !abort) begin
                  result <= edge_next;
                  ovf    <= sat_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign ring_en = (state_q == SETTLE) || (state_q == COUNT);
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);

endmodule

// File: doc/ring_osc_freq_meter.md
Name: ring_osc_freq_meter

Overview:
Measures a free-running ring oscillator output in the system clock domain. It enables the ring, waits a settle period, then counts ring rising edges over a programmable gate window of clk cycles. It reports the edge count with a one-cycle done pulse. It sits beside each ring oscillator instance, driving the ring's enable and reading its output, so software or a top-level FSM can read oscillator frequency as count/gate_len * f_clk.

Parameters:
CNT_W, 24, width of edge counter and result.
GATE_W, 20, width of gate_len input and internal gate counter.
SETTLE_CYCLES, 16, clk cycles ring_en is high before counting starts (must be >= 1).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a measurement; sampled only in IDLE.
abort  input  1  cancel measurement in progress.
gate_len  input  GATE_W  gate window length in clk cycles; latched on accepted start.
ring_in  input  1  raw ring oscillator output, asynchronous to clk.
ring_en  output  1  enable to the ring oscillator.
busy  output  1  high while state != IDLE.
done  output  1  one-cycle pulse when result is updated.
result  output  CNT_W  rising-edge count of last completed measurement.
ovf  output  1  set if the last completed measurement saturated.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ring_en=0, busy=0, done=0, result=0, ovf=0, synchronizer flops=0, counters=0.
- ring_in passes through a 2-flop synchronizer (s1, s2) plus a history flop s3. rise = s2 & ~s3. Bench contract: ring_in high and low phases are each >= 2 clk periods. Faster rings alias and are out of scope.
- States: IDLE, SETTLE, COUNT, DONE.
- IDLE: ring_en=0. If start=1 (and abort=0), latch gate_len into gate_q. Then go to SETTLE, loading settle counter with SETTLE_CYCLES-1, or go to DONE directly if gate_len==0 (result=0, ovf=0).
- SETTLE: ring_en=1. Stays for exactly SETTLE_CYCLES cycles. Edges are not counted. Then go to COUNT, with edge counter cleared to 0 and gate counter loaded with gate_q-1.
- COUNT: ring_en=1. Lasts exactly gate_q cycles. Each cycle where rise=1 increments the edge counter. The counter saturates at 2^CNT_W-1, and an internal sat flag sets if an increment is attempted at max. After the last COUNT cycle, including a rise in that cycle, go to DONE.
- DONE: one cycle. done=1. result<=edge count, ovf<=sat, ring_en=0. Next state is IDLE.
- busy = (state != IDLE). busy is high from the cycle after an accepted start through the DONE cycle inclusive.
- Latency: start sampled at edge k. done is high during cycle k+1+SETTLE_CYCLES+gate_q.
- start while busy: ignored, no queuing.
- abort=1 in SETTLE or COUNT: go to IDLE next cycle. ring_en=0, no done pulse, result and ovf unchanged. abort in IDLE or DONE: no effect; DONE still completes.
- start and abort both high in IDLE: abort wins, so start is not accepted.
- gate_len changes while busy: no effect (gate_q is used).
- result and ovf hold their values between measurements. They change only in DONE.
- Reset mid-operation: immediate return to reset values, including result=0.

Test Plan:
- ring_in square wave with period 10 clk (5 high/5 low), gate_len=1000, start pulse -> ring_en high for 16+1000 cycles, done at start+1017, result=100 (±1), ovf=0, busy low the cycle after done.
- CNT_W=4, ring_in period 4 clk, gate_len=200 -> result=15, ovf=1. Second run with gate_len=40 -> result=10, ovf=0.
- gate_len=0, start -> done one cycle after start edge, result=0, ovf=0, ring_en never high.
- Start a gate_len=1000 run, pulse start again at cycle 300 with gate_len=5 -> ignored; done at the original time with result for a 1000-cycle gate.
- Complete a measurement (result=100), then start a new one and assert abort in COUNT -> IDLE next cycle, ring_en=0, no done, result stays 100.
- Deassert rst_n mid-COUNT for 1 cycle (asynchronously, between clk edges) -> all outputs 0 immediately. A subsequent start performs a normal full measurement.
